lcd_spi_deserializer: RTL and testbench
=======================================

// Module: lcd_spi_deserializer
// PURPOSE
//  Receive side of the streaming LCD SPI link: samples the serial clock/data/CS pins and rebuilds MSB-first words.
//  Runs on a system clock at least 4x the link SCLK rate; pins are treated as asynchronous.
//  Pushes each complete 8- or 16-bit word into a downstream write-only FIFO.
//  Used as the link-side front end for loopback test and display-emulation builds.
// PARAMETERS
//  SYNC_STAGES     2     synchronizer flops on spi_csn/spi_sclk/spi_data (min 2)
//  TIMEOUT_CYCLES  1024  clk cycles without SCLK rise before a partial word is aborted (LCD_RX_TIMEOUT_EN only)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-high reset
//  spi_csn      in   1   frame select, active low, async to clk
//  spi_sclk     in   1   serial clock; idles low; data valid on rising edge
//  spi_data     in   1   serial data, MSB first
//  word16       in   1   word length for next frame: 0 = 8 bit, 1 = 16 bit; sampled at frame start
//  q_full       in   1   downstream FIFO full
//  q_write      out  1   one-cycle push strobe
//  q_data       out  16  received word; 8-bit words right-aligned, [15:8] = 0
//  q_is16       out  1   1 = q_data holds a 16-bit word
//  rx_busy      out  1   high while a frame is open (state SHIFT)
//  clr_err      in   1   clears err_overflow and err_partial
//  err_overflow out  1   sticky: word dropped because q_full
//  err_partial  out  1   sticky: word discarded incomplete
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, bit counter 0, shift register 0, synchronizers 0 (csn sync preset 1).
//  - All three pins pass through SYNC_STAGES flops plus one history flop; rise = sclk_sync & ~sclk_hist.
//  - Data bit taken from the data synchronizer in the same cycle as rise (equal path depth keeps them aligned).
//  - SCLK high and low phases must each be >= 2 clk periods; narrower pulses are unsupported.
//  - States: IDLE (csn sync high), SHIFT (csn sync low).
//  - IDLE -> SHIFT on csn sync low: bitcnt <= 0, len latched from word16 (8 or 16); word16 ignored until next frame.
//  - SHIFT, on rise: sr <= {sr[14:0], data}; bitcnt++; when bitcnt reaches len: push word, bitcnt <= 0.
//  - Words are back to back within a frame; no gap required between words.
//  - Push: q_write high exactly 1 cycle, q_data/q_is16 valid same cycle and held until next push.
//  - Latency: q_write asserts SYNC_STAGES+1 clk cycles after the pin-level final SCLK rise.
//  - Push with q_full high: word dropped, q_write stays 0, err_overflow <= 1.
//  - SHIFT -> IDLE on csn sync high: if bitcnt != 0, partial word discarded, err_partial <= 1; bitcnt <= 0.
//  - rise and csn deassert in the same cycle: bit is shifted (and a word pushed if complete) before the frame closes.
//  - clr_err in the same cycle as a new error: the error wins (flag stays 1).
//  - SCLK rises while in IDLE: ignored.
//  - Reset asserted mid-frame: immediate return to reset state; partial word lost, no flag set.
//  - bitcnt is 5 bits; it never exceeds 16.
// CONFIGURATION
//  LCD_RX_TIMEOUT_EN defined:
//    - 10-bit+ idle counter runs in SHIFT while bitcnt != 0, cleared on every rise.
//    - At TIMEOUT_CYCLES: partial word discarded, bitcnt <= 0, err_partial <= 1; state stays SHIFT.
//  LCD_RX_TIMEOUT_EN undefined:
//    - No counter; a partial word is held until more bits arrive or csn deasserts.
// TESTING
//  1. csn low, word16=0, shift 0xA5, csn high -> one q_write, q_data=0x00A5, q_is16=0, no errors.
//  2. word16=1, one frame carrying 0x1234 then 0xBEEF -> two pushes, 0x1234 then 0xBEEF, q_is16=1.
//  3. q_full=1 during the final bit of 0x5A -> no q_write, err_overflow=1; clr_err pulse -> 0.
//  4. word16=0, 5 bits then csn high -> no push, err_partial=1, next frame 0x3C received correctly.
//  5. csn rises in the same cycle as the 8th sync rise of 0xC3 -> push 0xC3, err_partial=0.
//  6. LCD_RX_TIMEOUT_EN: 3 bits then SCLK stalls 1024 cycles -> err_partial=1, next 8 bits 0x81 pushed.

Source files
------------

// File: rtl/lcd_spi_deserializer.sv
// lcd_spi_deserializer: SPI link receiver rebuilding MSB-first 8/16-bit words into a write-only FIFO; LCD_RX_TIMEOUT_EN adds a stalled-word abort
module lcd_spi_deserializer #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_csn,
   input  logic        spi_sclk,
   input  logic        spi_data,
   input  logic        word16,
   input  logic        q_full,
   output logic        q_write,
   output logic [15:0] q_data,
   output logic        q_is16,
   output logic        rx_busy,
   input  logic        clr_err,
   output logic        err_overflow,
   output logic        err_partial
);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state;
   logic [SYNC_STAGES-1:0] csn_ff, sclk_ff, data_ff;
   logic sclk_hist, len16;
   logic [4:0] bitcnt, nb;
   logic [15:0] sr, word;
   logic csn_s, sclk_s, data_s, rise, done, tmo;
   assign csn_s = csn_ff[SYNC_STAGES-1];
   assign sclk_s = sclk_ff[SYNC_STAGES-1];
   assign data_s = data_ff[SYNC_STAGES-1];
   assign rise = sclk_s & ~sclk_hist;
   assign nb = rise ? bitcnt + 5'd1 : bitcnt;
   assign done = rise && nb == (len16 ? 5'd16 : 5'd8);
   assign word = {sr[14:0], data_s};
   assign rx_busy = state == SHIFT;
   // equal-depth pin synchronizers keep data aligned with the detected SCLK rise
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         csn_ff <= '1;
         sclk_ff <= '0;
         data_ff <= '0;
         sclk_hist <= 1'b0;
      end else begin
         csn_ff <= {csn_ff[SYNC_STAGES-2:0], spi_csn};
         sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], spi_sclk};
         data_ff <= {data_ff[SYNC_STAGES-2:0], spi_data};
         sclk_hist <= sclk_s;
      end
`ifdef LCD_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1 < 10 ? 10 : $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] idle_cnt;
   assign tmo = state == SHIFT && bitcnt != 0 && !rise && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
   // counts clk cycles a partial word has waited for its next SCLK rise
   always_ff @(posedge clk or posedge rst)
      if (rst)
         idle_cnt <= '0;
      else
         idle_cnt <= (state == SHIFT && bitcnt != 0 && !rise && !tmo) ? idle_cnt + 1'b1 : '0;
`else
   assign tmo = 1'b0;
`endif
   // frame FSM: word assembly, FIFO push and sticky error flags (new errors beat clr_err)
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         bitcnt <= '0;
         sr <= '0;
         len16 <= 1'b0;
         q_write <= 1'b0;
         q_data <= '0;
         q_is16 <= 1'b0;
         err_overflow <= 1'b0;
         err_partial <= 1'b0;
      end else begin
         q_write <= 1'b0;
         if (clr_err) begin
            err_overflow <= 1'b0;
            err_partial <= 1'b0;
         end
         if (state == IDLE) begin
            if (!csn_s) begin
               state <= SHIFT;
               bitcnt <= '0;
               len16 <= word16;
            end
         end else begin
            if (rise) sr <= word;
            bitcnt <= (done || tmo) ? 5'd0 : nb;
            if (done && q_full) err_overflow <= 1'b1;
            if (done && !q_full) begin
               q_write <= 1'b1;
               q_data <= len16 ? word : {8'h00, word[7:0]};
               q_is16 <= len16;
            end
            if (tmo || (csn_s && !done && nb != 0)) err_partial <= 1'b1;
            if (csn_s) begin
               state <= IDLE;
               bitcnt <= '0;
            end
         end
      end
endmodule

// File: tb/tb_lcd_spi_deserializer.sv
// tb_lcd_spi_deserializer: directed vectors for lcd_spi_deserializer; define LCD_RX_TIMEOUT_EN to match a timeout build
module tb_lcd_spi_deserializer;
   logic clk = 0, rst = 1, spi_csn = 1, spi_sclk = 0, spi_data = 0, word16 = 0, q_full = 0, clr_err = 0;
   logic q_write, q_is16, rx_busy, err_overflow, err_partial;
   logic [15:0] q_data;
   int n_vec = 0, n_err = 0, cyc = 0, rise_cyc = 0, push_cyc = 0;
   logic [16:0] pq[$];

   lcd_spi_deserializer dut (
      .clk(clk), .rst(rst), .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_data(spi_data),
      .word16(word16), .q_full(q_full), .q_write(q_write), .q_data(q_data), .q_is16(q_is16),
      .rx_busy(rx_busy), .clr_err(clr_err), .err_overflow(err_overflow), .err_partial(err_partial)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // log every push as {q_is16, q_data}
   always @(negedge clk)
      if (q_write) begin
         pq.push_back({q_is16, q_data});
         push_cyc = cyc;
      end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic bit_out(input logic b, input logic close);
      spi_data = b;
      tick(4);
      spi_sclk = 1;
      if (close) spi_csn = 1;
      rise_cyc = cyc;
      tick(4);
      spi_sclk = 0;
   endtask
   task automatic send(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) bit_out(v[i], 1'b0);
   endtask
   task automatic open_frame(input logic w16);
      word16 = w16;
      spi_csn = 0;
      tick(4);
   endtask
   task automatic close_frame;
      tick(2);
      spi_csn = 1;
      tick(6);
   endtask
   task automatic pop(input string tag, input logic [16:0] exp);
      if (pq.size() > 0) check(tag, pq.pop_front(), exp);
   endtask
   task automatic clear_errors;
      clr_err = 1;
      tick(1);
      clr_err = 0;
      tick(1);
   endtask

   initial begin
      tick(3);
      check("reset q_write", q_write, 0);
      check("reset q_data", q_data, 0);
      check("reset flags", {q_is16, rx_busy, err_overflow, err_partial}, 0);
      rst = 0;
      tick(2);
      // 1: single 8-bit word
      open_frame(0);
      check("t1 busy", rx_busy, 1);
      send(16'h00A5, 8);
      check("t1 latency", push_cyc - rise_cyc, 3);
      close_frame;
      check("t1 count", pq.size(), 1);
      pop("t1 word", 17'h000A5);
      check("t1 errors", {err_overflow, err_partial}, 0);
      check("t1 idle", rx_busy, 0);
      // 2: two back-to-back 16-bit words; word16 changes mid-frame are ignored
      open_frame(1);
      word16 = 0;
      send(16'h1234, 16);
      send(16'hBEEF, 16);
      close_frame;
      check("t2 count", pq.size(), 2);
      pop("t2 word0", 17'h11234);
      pop("t2 word1", 17'h1BEEF);
      check("t2 partial", err_partial, 0);
      // 3: overflow on final bit, then clear
      open_frame(0);
      send(16'h005A >> 1, 7);
      q_full = 1;
      send(16'h0000, 1);
      q_full = 0;
      close_frame;
      check("t3 count", pq.size(), 0);
      check("t3 overflow", err_overflow, 1);
      clear_errors;
      check("t3 cleared", err_overflow, 0);
      // 4: partial word, then a good frame
      open_frame(0);
      send(16'h0016, 5);
      close_frame;
      check("t4 count", pq.size(), 0);
      check("t4 partial", err_partial, 1);
      open_frame(0);
      send(16'h003C, 8);
      close_frame;
      check("t4 count2", pq.size(), 1);
      pop("t4 word", 17'h0003C);
      check("t4 sticky", err_partial, 1);
      clear_errors;
      check("t4 cleared", err_partial, 0);
      // 5: csn deasserts together with the 8th rise
      open_frame(0);
      send(16'h00C3 >> 1, 7);
      bit_out(1'b1, 1'b1);
      tick(6);
      check("t5 count", pq.size(), 1);
      pop("t5 word", 17'h000C3);
      check("t5 partial", err_partial, 0);
      // 6: clr_err in the same cycle as an overflow: error wins
      open_frame(0);
      send(16'h0066 >> 1, 7);
      q_full = 1;
      spi_data = 0;
      tick(4);
      spi_sclk = 1;
      tick(2);
      clr_err = 1;
      tick(1);
      clr_err = 0;
      check("t6 err wins", err_overflow, 1);
      tick(1);
      spi_sclk = 0;
      q_full = 0;
      close_frame;
      check("t6 count", pq.size(), 0);
      clear_errors;
      check("t6 cleared", err_overflow, 0);
      // 7: SCLK toggling with csn high is ignored
      send(16'h00FF, 8);
      tick(6);
      check("t7 count", pq.size(), 0);
      check("t7 flags", {rx_busy, err_partial}, 0);
      // 8: long SCLK stall after 3 bits
      open_frame(0);
      send(16'h0005, 3);
      tick(1100);
`ifdef LCD_RX_TIMEOUT_EN
      check("t8 timeout", err_partial, 1);
      send(16'h0081, 8);
      close_frame;
      check("t8 count", pq.size(), 1);
      pop("t8 word", 17'h00081);
      clear_errors;
`else
      check("t8 held", err_partial, 0);
      send(16'h0011, 5);
      close_frame;
      check("t8 count", pq.size(), 1);
      pop("t8 word", 17'h000B1);
`endif
      check("t8 partial", err_partial, 0);
      // 9: reset mid-frame
      open_frame(0);
      send(16'h000A, 4);
      rst = 1;
      tick(1);
      check("t9 busy", rx_busy, 0);
      check("t9 data", q_data, 0);
      spi_csn = 1;
      tick(1);
      rst = 0;
      tick(6);
      check("t9 count", pq.size(), 0);
      check("t9 partial", err_partial, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
